// File: rtl/star_pkt_fifo.sv
// Store-and-forward packet FIFO behind the star_arb chain: a packet becomes visible
// on res_* only once its TLAST beat is stored, unless an oversized packet forces cut-through.
module star_pkt_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] src_TDATA,
    input  logic                  src_TVALID,
    output logic                  src_TREADY,
    input  logic                  src_TLAST,
    output logic [DATA_WIDTH-1:0] res_TDATA,
    output logic                  res_TVALID,
    input  logic                  res_TREADY,
    output logic                  res_TLAST,
    output logic [ADDR_WIDTH:0]   level,
    output logic [ADDR_WIDTH:0]   pkt_cnt,
    output logic                  overflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
    logic                full, empty;
    logic                wr_en, rd_en;
    logic                release_q, rel_wr_q, overflow_q;
    logic                rel_set, rel_now;
    logic                pkt_inc, pkt_dec;

    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // Full with no complete packet stored means one packet exceeds DEPTH; it is
    // released immediately so the sink can start draining in the same cycle.
    assign rel_set = full && (pkt_cnt == '0) && !release_q;
    assign rel_now = release_q || rel_set;

    assign src_TREADY = rst && !full;
    assign res_TVALID = !empty && ((pkt_cnt != '0) || rel_now);
    assign {res_TLAST, res_TDATA} = mem[rd_ptr[ADDR_WIDTH-1:0]];

    assign wr_en = src_TVALID && src_TREADY;
    assign rd_en = res_TVALID && res_TREADY;

    assign level    = wr_ptr - rd_ptr;
    assign overflow = overflow_q || rel_set;

    // The released packet is never counted, on either side.
    assign pkt_inc = wr_en && src_TLAST && !rel_wr_q;
    assign pkt_dec = rd_en && res_TLAST && !rel_now;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {src_TLAST, src_TDATA};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt <= '0;
        end else begin
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_cnt <= pkt_cnt + PTR_ONE;
                2'b01:   pkt_cnt <= pkt_cnt - PTR_ONE;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    // release_q tracks the read side of the released packet, rel_wr_q the write side
    // (its TLAST may still be upstream when release starts).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            release_q  <= 1'b0;
            rel_wr_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (rel_set) begin
                release_q  <= 1'b1;
                rel_wr_q   <= 1'b1;
                overflow_q <= 1'b1;
            end else begin
                if (rd_en && res_TLAST && release_q) release_q <= 1'b0;
                if (wr_en && src_TLAST && rel_wr_q)  rel_wr_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_star_pkt_fifo.sv
// Scoreboard bench for star_pkt_fifo: accepted writes push expected beats, a negedge
// monitor pops and compares every beat the sink takes.
module tb_star_pkt_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] src_TDATA;
    logic       src_TVALID;
    logic       src_TREADY;
    logic       src_TLAST;
    logic [7:0] res_TDATA;
    logic       res_TVALID;
    logic       res_TREADY;
    logic       res_TLAST;
    logic [4:0] level;
    logic [4:0] pkt_cnt;
    logic       overflow;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_exp;
    bit         pk_bad;
    bit         seen_full;

    star_pkt_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .src_TDATA(src_TDATA), .src_TVALID(src_TVALID), .src_TREADY(src_TREADY), .src_TLAST(src_TLAST),
        .res_TDATA(res_TDATA), .res_TVALID(res_TVALID), .res_TREADY(res_TREADY), .res_TLAST(res_TLAST),
        .level(level), .pkt_cnt(pkt_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pclk();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] d, input logic l);
        bit ok = 0;
        src_TDATA  = d;
        src_TLAST  = l;
        src_TVALID = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (src_TREADY) begin
                exp_q.push_back({l, d});
                ok = 1;
            end
            pclk();
        end
        src_TVALID = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && level == 0) break;
        end
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        chk({name, "_level_zero"}, int'(level), 0);
        pclk();
    endtask

    always @(negedge clk) begin
        if (rst && res_TVALID && res_TREADY) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL monitor_beat: got %0h with no beat expected", {res_TLAST, res_TDATA});
            end else begin
                mon_exp = exp_q.pop_front();
                if ({res_TLAST, res_TDATA} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL monitor_beat: got %0h expected %0h", {res_TLAST, res_TDATA}, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with a pending write
        rst = 1'b0; src_TVALID = 1'b1; src_TDATA = 8'hee; src_TLAST = 1'b1; res_TREADY = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_src_TREADY", int'(src_TREADY), 0);
        chk("rst_res_TVALID", int'(res_TVALID), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_pkt_cnt", int'(pkt_cnt), 0);
        chk("rst_overflow", int'(overflow), 0);
        src_TVALID = 1'b0;
        pclk();
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_src_TREADY", int'(src_TREADY), 1);
        pclk();

        // Three-beat packet held until its TLAST is stored
        res_TREADY = 1'b1;
        send(8'h10, 1'b0);
        @(negedge clk); chk("t2_hold_after_b0", int'(res_TVALID), 0); pclk();
        send(8'h11, 1'b0);
        @(negedge clk); chk("t2_hold_after_b1", int'(res_TVALID), 0); pclk();
        send(8'h12, 1'b1);
        @(negedge clk);
        chk("t2_valid_after_last", int'(res_TVALID), 1);
        chk("t2_pkt_cnt_1", int'(pkt_cnt), 1);
        chk("t2_level_3", int'(level), 3);
        pclk(); @(negedge clk); chk("t2_pkt_cnt_mid", int'(pkt_cnt), 1);
        pclk(); @(negedge clk); chk("t2_pkt_cnt_last", int'(pkt_cnt), 1);
        pclk(); @(negedge clk);
        chk("t2_pkt_cnt_0", int'(pkt_cnt), 0);
        chk("t2_valid_done", int'(res_TVALID), 0);
        pclk();

        // Fill with 16 one-beat packets, then drain
        res_TREADY = 1'b0;
        for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 1'b1);
        @(negedge clk);
        chk("t3_level_16", int'(level), 16);
        chk("t3_pkt_cnt_16", int'(pkt_cnt), 16);
        chk("t3_src_TREADY_full", int'(src_TREADY), 0);
        chk("t3_overflow_0", int'(overflow), 0);
        pclk();
        res_TREADY = 1'b1;
        @(negedge clk); chk("t3_ready_before_read", int'(src_TREADY), 0); pclk();
        @(negedge clk);
        chk("t3_ready_after_read", int'(src_TREADY), 1);
        chk("t3_level_15", int'(level), 15);
        pclk();
        drain("t3");
        chk("t3_pkt_cnt_end", int'(pkt_cnt), 0);

        // Oversized 20-beat packet forces cut-through
        pk_bad = 0; seen_full = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) send(8'(8'h40 + i), (i == 19));
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    @(negedge clk);
                    if (pkt_cnt != 0) pk_bad = 1;
                    if (!seen_full && level == 16) begin
                        seen_full = 1;
                        chk("t4_overflow_at_full", int'(overflow), 1);
                        chk("t4_valid_at_full", int'(res_TVALID), 1);
                    end
                end
            end
        join
        pclk();
        chk("t4_reached_full", int'(seen_full), 1);
        chk("t4_pkt_cnt_stayed_0", int'(pk_bad), 0);
        drain("t4");
        chk("t4_overflow_sticky", int'(overflow), 1);

        // Simultaneous TLAST write and TLAST read with pkt_cnt=2
        res_TREADY = 1'b0;
        send(8'h60, 1'b1);
        send(8'h61, 1'b1);
        @(negedge clk); chk("t5_pkt_cnt_pre", int'(pkt_cnt), 2); pclk();
        res_TREADY = 1'b1; src_TDATA = 8'h62; src_TLAST = 1'b1; src_TVALID = 1'b1;
        @(negedge clk);
        chk("t5_src_ready", int'(src_TREADY), 1);
        if (src_TREADY) exp_q.push_back({1'b1, 8'h62});
        pclk();
        res_TREADY = 1'b0; src_TVALID = 1'b0;
        @(negedge clk);
        chk("t5_pkt_cnt_same", int'(pkt_cnt), 2);
        chk("t5_level_same", int'(level), 2);
        pclk();
        res_TREADY = 1'b1;
        drain("t5");

        // Asynchronous reset mid-packet
        res_TREADY = 1'b0;
        send(8'h70, 1'b1);
        for (int i = 1; i < 5; i++) send(8'(8'h70 + i), 1'b0);
        @(negedge clk);
        chk("t6_level_5", int'(level), 5);
        chk("t6_pkt_cnt_1", int'(pkt_cnt), 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_level", int'(level), 0);
        chk("t6_async_pkt_cnt", int'(pkt_cnt), 0);
        chk("t6_async_valid", int'(res_TVALID), 0);
        chk("t6_async_src_ready", int'(src_TREADY), 0);
        chk("t6_overflow_cleared", int'(overflow), 0);
        exp_q.delete();
        pclk();
        rst = 1'b1;
        res_TREADY = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_no_stale_valid", int'(res_TVALID), 0);
        pclk();
        send(8'h80, 1'b1);
        drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
